// File: rtl/robot_pkg.sv
// rtl/robot_pkg.sv - shared state and direction naming for the robot navigation and drive stages
package robot_pkg;

    typedef enum logic [1:0] {IDLE, FORWARD, BRAKE, TURN} state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Rotate outranks forward; no command means stop.
    function automatic state_t cmd_target(input logic fs, input logic rs);
        if (rs)
            return TURN;
        else if (fs)
            return FORWARD;
        return IDLE;
    endfunction

endpackage

// File: rtl/motor_driver_if.sv
// rtl/motor_driver_if.sv - command inputs and H-bridge outputs of the motor driver
interface motor_driver_if;
    logic front;
    logic rotate;
    logic pwm_l;
    logic pwm_r;
    logic dir_l;
    logic dir_r;
    logic busy;
    logic turn_done;

    modport master (
        output front, rotate,
        input  pwm_l, pwm_r, dir_l, dir_r, busy, turn_done
    );

    modport slave (
        input  front, rotate,
        output pwm_l, pwm_r, dir_l, dir_r, busy, turn_done
    );
endinterface

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - restartable PWM generator with registered output and end-of-period strobe
module pwm_gen #(
    parameter int PWM_PERIOD = 100
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              restart,
    input  logic [$clog2(PWM_PERIOD+1)-1:0]   duty,
    output logic                              pwm,
    output logic                              period_end
);

    localparam int CW = $clog2(PWM_PERIOD);
    localparam int DW = $clog2(PWM_PERIOD + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        cnt_inc = (cnt == CW'(PWM_PERIOD - 1)) ? '0 : cnt + CW'(1);
    end

    // cnt always holds the phase that pwm is currently showing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            pwm <= 1'b0;
        end else if (restart) begin
            cnt <= '0;
            pwm <= (duty != '0);
        end else begin
            cnt <= cnt_inc;
            pwm <= (DW'(cnt_inc) < duty);
        end
    end

    assign period_end = (cnt == CW'(PWM_PERIOD - 1));

endmodule

// File: rtl/motor_driver.sv
// rtl/motor_driver.sv - turns front/rotate commands into wheel PWM and direction with braking dead time
module motor_driver
    import robot_pkg::*;
#(
    parameter int PWM_PERIOD   = 100,
    parameter int DUTY_FWD     = 75,
    parameter int DUTY_TURN    = 50,
    parameter int TURN_PERIODS = 20,
    parameter int DEAD_TICKS   = 8
) (
    input logic            clk,
    input logic            rst_n,
    motor_driver_if.slave  bus
);

    localparam int DW = $clog2(PWM_PERIOD + 1);
    localparam int TW = $clog2(TURN_PERIODS + 1);
    localparam int KW = $clog2(DEAD_TICKS + 1);

    logic          front_q1, rotate_q1, fs, rs;
    state_t        state, state_d;
    logic [TW-1:0] turn_cnt;
    logic [KW-1:0] dead_cnt;
    logic          dir_l_q, dir_r_q, dir_l_d, dir_r_d;
    logic          busy_q, turn_done_q;
    logic          step_done, dead_done, restart;
    logic [DW-1:0] duty_d;
    logic          pwm, period_end;

    always_comb begin
        state_d   = state;
        dir_l_d   = dir_l_q;
        dir_r_d   = dir_r_q;
        step_done = (state == TURN) && period_end && (turn_cnt == TW'(TURN_PERIODS - 1));
        dead_done = (state == BRAKE) && (dead_cnt == KW'(DEAD_TICKS - 1));
        case (state)
            IDLE: begin
                if (rs)
                    state_d = BRAKE;
                else if (fs)
                    state_d = FORWARD;
            end
            FORWARD: begin
                if (rs)
                    state_d = BRAKE;
                else if (!fs)
                    state_d = IDLE;
            end
            BRAKE: begin
                // Target is sampled only now, so a dropped command lands in IDLE.
                if (dead_done) begin
                    state_d = cmd_target(fs, rs);
                    dir_l_d = DIR_FWD;
                    dir_r_d = (state_d == TURN) ? DIR_REV : DIR_FWD;
                end
            end
            TURN: begin
                if (step_done)
                    state_d = rs ? TURN : BRAKE;
            end
            default: state_d = IDLE;
        endcase
        restart = (state_d != state) || step_done;
        case (state_d)
            FORWARD: duty_d = DW'(DUTY_FWD);
            TURN:    duty_d = DW'(DUTY_TURN);
            default: duty_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_q1    <= 1'b0;
            rotate_q1   <= 1'b0;
            fs          <= 1'b0;
            rs          <= 1'b0;
            state       <= IDLE;
            turn_cnt    <= '0;
            dead_cnt    <= '0;
            dir_l_q     <= 1'b0;
            dir_r_q     <= 1'b0;
            busy_q      <= 1'b0;
            turn_done_q <= 1'b0;
        end else begin
            front_q1    <= bus.front;
            rotate_q1   <= bus.rotate;
            fs          <= front_q1;
            rs          <= rotate_q1;
            state       <= state_d;
            dir_l_q     <= dir_l_d;
            dir_r_q     <= dir_r_d;
            busy_q      <= (state_d == BRAKE) || (state_d == TURN);
            turn_done_q <= step_done;
            if (state_d != state)
                dead_cnt <= '0;
            else if (state == BRAKE)
                dead_cnt <= dead_cnt + KW'(1);
            if (restart)
                turn_cnt <= '0;
            else if ((state == TURN) && period_end)
                turn_cnt <= turn_cnt + TW'(1);
        end
    end

    // Both wheels always share one duty, so a single generator feeds both.
    pwm_gen #(.PWM_PERIOD(PWM_PERIOD)) u_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .duty       (duty_d),
        .pwm        (pwm),
        .period_end (period_end)
    );

    assign bus.pwm_l     = pwm;
    assign bus.pwm_r     = pwm;
    assign bus.dir_l     = dir_l_q;
    assign bus.dir_r     = dir_r_q;
    assign bus.busy      = busy_q;
    assign bus.turn_done = turn_done_q;

endmodule

// File: tb/tb_motor_driver.sv
// tb/tb_motor_driver.sv - segment-table scoreboard bench for motor_driver
module tb_motor_driver;

    localparam int P = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    motor_driver_if bus();

    motor_driver #(
        .PWM_PERIOD   (10),
        .DUTY_FWD     (7),
        .DUTY_TURN    (5),
        .TURN_PERIODS (3),
        .DEAD_TICKS   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Each segment: inputs applied on its first cycle, then expected outputs for n cycles.
    typedef struct {
        logic f;
        logic r;
        int   n;
        int   duty;
        int   ph;
        logic dl;
        logic dr;
        logic bz;
        int   td;
        logic glitch;
        logic rst;
    } seg_t;

    seg_t       segs[15];
    logic [5:0] exp_q[$];
    logic [5:0] act;
    int         n_cmp = 0;
    int         n_bad = 0;

    assign act = {bus.pwm_l, bus.pwm_r, bus.dir_l, bus.dir_r, bus.busy, bus.turn_done};

    function automatic seg_t mk(input logic f, input logic r, input int n, input int duty,
                                input int ph, input logic dl, input logic dr, input logic bz,
                                input int td, input logic gl, input logic rs);
        seg_t s;
        s.f = f; s.r = r; s.n = n; s.duty = duty; s.ph = ph;
        s.dl = dl; s.dr = dr; s.bz = bz; s.td = td; s.glitch = gl; s.rst = rs;
        return s;
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got {pwm_l,pwm_r,dir_l,dir_r,busy,turn_done}=%b expected %b",
                     name, got, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        segs[0]  = mk(1, 0,  3, 0, 0, 0, 0, 0, -1, 0, 0);
        segs[1]  = mk(1, 0, 25, 7, 0, 0, 0, 0, -1, 0, 0);
        segs[2]  = mk(1, 1,  3, 7, 5, 0, 0, 0, -1, 0, 0);
        segs[3]  = mk(1, 1,  4, 0, 0, 0, 0, 1, -1, 0, 0);
        segs[4]  = mk(1, 1, 30, 5, 0, 0, 1, 1, -1, 0, 0);
        segs[5]  = mk(1, 1,  5, 5, 0, 0, 1, 1,  0, 0, 0);
        segs[6]  = mk(1, 0, 25, 5, 5, 0, 1, 1, -1, 0, 0);
        segs[7]  = mk(1, 0,  4, 0, 0, 0, 1, 1,  0, 0, 0);
        segs[8]  = mk(1, 0, 15, 7, 0, 0, 0, 0, -1, 1, 0);
        segs[9]  = mk(0, 0,  3, 7, 5, 0, 0, 0, -1, 0, 0);
        segs[10] = mk(0, 0,  5, 0, 0, 0, 0, 0, -1, 0, 0);
        segs[11] = mk(1, 1,  3, 0, 0, 0, 0, 0, -1, 0, 0);
        segs[12] = mk(1, 1,  4, 0, 0, 0, 0, 1, -1, 0, 0);
        segs[13] = mk(1, 1, 12, 5, 0, 0, 1, 1, -1, 0, 0);
        segs[14] = mk(0, 0, 40, 0, 0, 0, 0, 0, -1, 0, 1);

        bus.front  = 1'b0;
        bus.rotate = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", act, 6'b000000);
        rst_n = 1'b1;

        for (int s = 0; s < 15; s++) begin
            for (int k = 0; k < segs[s].n; k++) begin
                logic p;
                p = (((segs[s].ph + k) % P) < segs[s].duty);
                exp_q.push_back({p, p, segs[s].dl, segs[s].dr, segs[s].bz, (k == segs[s].td)});
            end
            for (int i = 0; i < segs[s].n; i++) begin
                @(posedge clk);
                #1;
                if (i == 0) begin
                    bus.front  = segs[s].f;
                    bus.rotate = segs[s].r;
                    if (segs[s].glitch) begin
                        bus.rotate = 1'b1;
                        #2 bus.rotate = segs[s].r;
                    end
                    if (segs[s].rst) begin
                        #1 rst_n = 1'b0;
                        #1 check("async_reset", act, 6'b000000);
                    end
                end
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard_underflow: seg %0d cycle %0d has no expectation", s, i);
                end else begin
                    check($sformatf("seg%0d_cyc%0d", s, i), act, exp_q.pop_front());
                end
                if (segs[s].rst && i == 0)
                    #2 rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
